// File: rtl/ls_agu_pkg.sv
// ls_agu shared types: funct3 encodings and FSM states.
// Imported by ls_align and ls_agu.
package ls_agu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [2:0] {
        AG_IDLE,
        AG_REQ,
        AG_DATA,
        AG_RESP,
        AG_FRESP
    } ag_state_e;

endpackage

// File: rtl/ls_align.sv
// ls_align: alignment/legality check, store lane formatting,
// and load lane extraction with sign/zero extension.
module ls_align
    import ls_agu_pkg::*;
(
    input  logic [1:0]  ofs,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic [31:0] sdat,
    input  logic [31:0] rdat,
    output logic        fault,
    output logic [3:0]  wen,
    output logic [31:0] wdat,
    output logic [31:0] ldat
);

    logic [31:0] lane;

    // decode size, check alignment, format store and load lanes
    always_comb begin
        fault = 1'b0;
        wen   = 4'b0000;
        wdat  = 32'h0;
        ldat  = 32'h0;
        lane  = rdat >> {ofs, 3'b000};
        unique case (funct3)
            LS_B: begin
                wen  = 4'b0001 << ofs;
                wdat = {4{sdat[7:0]}};
                ldat = {{24{lane[7]}}, lane[7:0]};
            end
            LS_H: begin
                fault = ofs[0];
                wen   = 4'b0011 << ofs;
                wdat  = {2{sdat[15:0]}};
                ldat  = {{16{lane[15]}}, lane[15:0]};
            end
            LS_W: begin
                fault = |ofs;
                wen   = 4'b1111;
                wdat  = sdat;
                ldat  = lane;
            end
            LS_BU: begin
                fault = !is_load;
                ldat  = {24'h0, lane[7:0]};
            end
            LS_HU: begin
                fault = !is_load || ofs[0];
                ldat  = {16'h0, lane[15:0]};
            end
            default: fault = 1'b1;
        endcase
        if (is_load) begin
            wen  = 4'b0000;
            wdat = 32'h0;
        end
    end

endmodule

// File: rtl/ls_agu.sv
// ls_agu: load/store address generation and alignment stage.
// One op in flight: accept, request lsu, extract load, respond.
module ls_agu
    import ls_agu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ex4ag_val,
    output logic        hs_ag4ex_rdy,
    input  logic [31:0] i_base,
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_load,
    input  logic [31:0] i_sdat,
    input  logic [4:0]  i_rd,
    output logic        hs_ag4ls_val,
    input  logic        hs_ls4ag_rdy,
    output logic [31:0] o_ag_adr,
    output logic [31:0] o_ag_wdat,
    output logic [3:0]  o_ag_wen,
    output logic        o_ag_ren,
    input  logic [31:0] i_ls_rdat,
    output logic        hs_ag4wb_val,
    input  logic        hs_wb4ag_rdy,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic        o_fault,
    output logic [31:0] o_fault_adr
);

    ag_state_e   state, state_nxt;
    logic [31:0] ea_q, sdat_q, wb_dat_q;
    logic [2:0]  f3_q;
    logic        ld_q;
    logic [4:0]  rd_q;

    logic [31:0] ea_in;
    logic        idle, accept;
    logic [31:0] a_ea, a_sdat, a_wdat, a_ldat;
    logic [2:0]  a_f3;
    logic        a_ld, a_fault;
    logic [3:0]  a_wen;

    assign ea_in  = i_base + i_imm;
    assign idle   = (state == AG_IDLE);
    assign accept = idle && hs_ex4ag_val;

    // idle: judge the incoming op; otherwise work on the latched op
    assign a_ea   = idle ? ea_in     : ea_q;
    assign a_f3   = idle ? i_funct3  : f3_q;
    assign a_ld   = idle ? i_is_load : ld_q;
    assign a_sdat = idle ? i_sdat    : sdat_q;

    ls_align u_align (
        .ofs     (a_ea[1:0]),
        .funct3  (a_f3),
        .is_load (a_ld),
        .sdat    (a_sdat),
        .rdat    (i_ls_rdat),
        .fault   (a_fault),
        .wen     (a_wen),
        .wdat    (a_wdat),
        .ldat    (a_ldat)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= AG_IDLE;
        else     state <= state_nxt;
    end

    // next state and handshake/request outputs
    always_comb begin
        state_nxt    = state;
        hs_ag4ex_rdy = 1'b0;
        hs_ag4ls_val = 1'b0;
        hs_ag4wb_val = 1'b0;
        o_ag_adr     = 32'h0;
        o_ag_wdat    = 32'h0;
        o_ag_wen     = 4'b0000;
        o_ag_ren     = 1'b0;
        o_wb_we      = 1'b0;
        o_fault      = 1'b0;
        o_fault_adr  = 32'h0;
        unique case (state)
            AG_IDLE: begin
                hs_ag4ex_rdy = 1'b1;
                if (hs_ex4ag_val)
                    state_nxt = a_fault ? AG_FRESP : AG_REQ;
            end
            AG_REQ: begin
                hs_ag4ls_val = 1'b1;
                o_ag_adr     = {ea_q[31:2], 2'b00};
                o_ag_wdat    = a_wdat;
                o_ag_wen     = a_wen;
                o_ag_ren     = ld_q;
                if (hs_ls4ag_rdy)
                    state_nxt = ld_q ? AG_DATA : AG_RESP;
            end
            AG_DATA: state_nxt = AG_RESP;
            AG_RESP: begin
                hs_ag4wb_val = 1'b1;
                o_wb_we      = ld_q;
                if (hs_wb4ag_rdy) state_nxt = AG_IDLE;
            end
            AG_FRESP: begin
                hs_ag4wb_val = 1'b1;
                o_fault      = 1'b1;
                o_fault_adr  = ea_q;
                if (hs_wb4ag_rdy) state_nxt = AG_IDLE;
            end
            default: state_nxt = AG_IDLE;
        endcase
    end

    // op latches and registered load result
    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q     <= 32'h0;
            sdat_q   <= 32'h0;
            f3_q     <= 3'b000;
            ld_q     <= 1'b0;
            rd_q     <= 5'h0;
            wb_dat_q <= 32'h0;
        end else begin
            if (accept) begin
                ea_q     <= ea_in;
                sdat_q   <= i_sdat;
                f3_q     <= i_funct3;
                ld_q     <= i_is_load;
                rd_q     <= i_rd;
                wb_dat_q <= 32'h0;
            end
            if (state == AG_DATA) wb_dat_q <= a_ldat;
        end
    end

    assign o_wb_rd  = rd_q;
    assign o_wb_dat = wb_dat_q;

endmodule

// File: tb/tb_ls_agu.sv
// tb_ls_agu: directed and random ops against an arithmetic
// reference model of the load/store address stage.
module tb_ls_agu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_ex4ag_val = 1'b0;
    logic        hs_ag4ex_rdy;
    logic [31:0] i_base = 32'h0;
    logic [31:0] i_imm = 32'h0;
    logic [2:0]  i_funct3 = 3'b0;
    logic        i_is_load = 1'b0;
    logic [31:0] i_sdat = 32'h0;
    logic [4:0]  i_rd = 5'h0;
    logic        hs_ag4ls_val;
    logic        hs_ls4ag_rdy = 1'b0;
    logic [31:0] o_ag_adr;
    logic [31:0] o_ag_wdat;
    logic [3:0]  o_ag_wen;
    logic        o_ag_ren;
    logic [31:0] i_ls_rdat = 32'h0;
    logic        hs_ag4wb_val;
    logic        hs_wb4ag_rdy = 1'b0;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_dat;
    logic        o_wb_we;
    logic        o_fault;
    logic [31:0] o_fault_adr;

    ls_agu dut (
        .clk          (clk),
        .rst          (rst),
        .hs_ex4ag_val (hs_ex4ag_val),
        .hs_ag4ex_rdy (hs_ag4ex_rdy),
        .i_base       (i_base),
        .i_imm        (i_imm),
        .i_funct3     (i_funct3),
        .i_is_load    (i_is_load),
        .i_sdat       (i_sdat),
        .i_rd         (i_rd),
        .hs_ag4ls_val (hs_ag4ls_val),
        .hs_ls4ag_rdy (hs_ls4ag_rdy),
        .o_ag_adr     (o_ag_adr),
        .o_ag_wdat    (o_ag_wdat),
        .o_ag_wen     (o_ag_wen),
        .o_ag_ren     (o_ag_ren),
        .i_ls_rdat    (i_ls_rdat),
        .hs_ag4wb_val (hs_ag4wb_val),
        .hs_wb4ag_rdy (hs_wb4ag_rdy),
        .o_wb_rd      (o_wb_rd),
        .o_wb_dat     (o_wb_dat),
        .o_wb_we      (o_wb_we),
        .o_fault      (o_fault),
        .o_fault_adr  (o_fault_adr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ls_hs = 0;
    int wb_hs = 0;

    always @(posedge clk) begin
        if (hs_ag4ls_val && hs_ls4ag_rdy) ls_hs++;
        if (hs_ag4wb_val && hs_wb4ag_rdy && o_wb_we) wb_hs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void model(
        input  logic [31:0] ea,
        input  logic [2:0]  f3,
        input  bit          ld,
        input  logic [31:0] sdat,
        input  logic [31:0] rdat,
        output bit          flt,
        output logic [3:0]  wen,
        output logic [31:0] wdat,
        output logic [31:0] res
    );
        int nb  = 1 << f3[1:0];
        int ofs = int'(ea[1:0]);
        bit legal = (f3 == 0 || f3 == 1 || f3 == 2)
                 || (ld && (f3 == 4 || f3 == 5));
        longint lane, m;
        flt  = !legal || (ofs % nb != 0);
        wen  = 4'h0;
        wdat = 32'h0;
        res  = 32'h0;
        if (flt) return;
        if (!ld) begin
            wen = 4'(((1 << nb) - 1) << ofs);
            if (nb == 1)      wdat = sdat[7:0] * 32'h01010101;
            else if (nb == 2) wdat = sdat[15:0] * 32'h00010001;
            else              wdat = sdat;
        end
        m    = longint'(1) << (8 * nb);
        lane = longint'(rdat >> (8 * ofs)) % m;
        if (!f3[2] && nb < 4 && lane >= m / 2) lane = lane - m;
        res = 32'(lane);
    endfunction

    task automatic do_op(
        input logic [31:0] base, input logic [31:0] imm,
        input logic [2:0] f3, input bit ld,
        input logic [31:0] sdat, input logic [4:0] rd,
        input logic [31:0] rdat, input int rs, input int ws
    );
        logic [31:0] ea;
        bit          flt;
        logic [3:0]  wen;
        logic [31:0] wdat, res;
        int          ls0;
        ea  = base + imm;
        model(ea, f3, ld, sdat, rdat, flt, wen, wdat, res);
        ls0 = ls_hs;
        chk("ex_rdy_idle", hs_ag4ex_rdy, 1);
        hs_ex4ag_val = 1'b1;
        i_base = base; i_imm = imm; i_funct3 = f3;
        i_is_load = ld; i_sdat = sdat; i_rd = rd;
        @(posedge clk); #1;
        hs_ex4ag_val = 1'b0;
        i_base = $urandom; i_imm = $urandom; i_sdat = $urandom;
        i_funct3 = 3'($urandom); i_is_load = 1'($urandom);
        i_rd = 5'($urandom);
        chk("ex_rdy_busy", hs_ag4ex_rdy, 0);
        if (flt) begin
            chk("fault", o_fault, 1);
            chk("fault_adr", o_fault_adr, ea);
            chk("fault_ls_val", hs_ag4ls_val, 0);
            chk("fault_we", o_wb_we, 0);
        end else begin
            for (int i = 0; i <= rs; i++) begin
                chk("req_val", hs_ag4ls_val, 1);
                chk("req_adr", o_ag_adr, {ea[31:2], 2'b00});
                chk("req_wen", o_ag_wen, wen);
                chk("req_wdat", o_ag_wdat, wdat);
                chk("req_ren", o_ag_ren, ld);
                chk("req_ex_rdy", hs_ag4ex_rdy, 0);
                if (i == rs) hs_ls4ag_rdy = 1'b1;
                @(posedge clk); #1;
                hs_ls4ag_rdy = 1'b0;
            end
            if (ld) begin
                i_ls_rdat = rdat;
                chk("data_ls_val", hs_ag4ls_val, 0);
                chk("data_wb_val", hs_ag4wb_val, 0);
                @(posedge clk); #1;
                i_ls_rdat = $urandom;
            end
            chk("resp_fault", o_fault, 0);
            chk("resp_we", o_wb_we, ld);
            if (ld) chk("resp_rd", o_wb_rd, rd);
        end
        chk("ls_handshakes", ls_hs - ls0, flt ? 0 : 1);
        for (int i = 0; i <= ws; i++) begin
            chk("wb_val", hs_ag4wb_val, 1);
            chk("wb_ex_rdy", hs_ag4ex_rdy, 0);
            if (ld && !flt) chk("wb_dat", o_wb_dat, res);
            if (flt) chk("wb_fault_adr", o_fault_adr, ea);
            if (i == ws) hs_wb4ag_rdy = 1'b1;
            @(posedge clk); #1;
            hs_wb4ag_rdy = 1'b0;
        end
        chk("post_wb_val", hs_ag4wb_val, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int ls0, wb0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ctl",
            {hs_ag4ex_rdy, hs_ag4ls_val, o_ag_wen, o_ag_ren,
             hs_ag4wb_val, o_wb_rd, o_wb_we, o_fault},
            32'h4000);
        chk("rst_adr", o_ag_adr, 0);
        chk("rst_wdat", o_ag_wdat, 0);
        chk("rst_wb_dat", o_wb_dat, 0);
        chk("rst_fault_adr", o_fault_adr, 0);

        do_op(32'h80000000, 32'd8, 3'b010, 0, 32'hDEADBEEF, 5'd1, 0, 0, 0);
        do_op(32'h80000000, 32'd3, 3'b000, 0, 32'h000000A5, 5'd2, 0, 0, 0);
        do_op(32'h80000000, 32'd1, 3'b000, 1, 0, 5'd7, 32'h00008000, 0, 0);
        do_op(32'h80000000, 32'd1, 3'b100, 1, 0, 5'd9, 32'h00008000, 0, 0);
        do_op(32'h80000000, 32'd2, 3'b010, 1, 0, 5'd3, 0, 0, 0);
        do_op(32'h10000000, 32'hFFFFFFFE, 3'b001, 1, 0, 5'd5,
              32'h8001_1234, 5, 3);
        do_op(32'h00000100, 32'd0, 3'b011, 1, 0, 5'd4, 0, 0, 1);
        do_op(32'h00000100, 32'd0, 3'b100, 0, 32'h55, 5'd4, 0, 0, 0);

        hs_ex4ag_val = 1'b1;
        i_base = 32'h2000; i_imm = 32'd2; i_funct3 = 3'b001;
        i_is_load = 1'b1; i_rd = 5'd11;
        @(posedge clk); #1;
        hs_ex4ag_val = 1'b0;
        chk("mid_req_val", hs_ag4ls_val, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ex_rdy", hs_ag4ex_rdy, 1);
        chk("mid_rst_ls_val", hs_ag4ls_val, 0);
        chk("mid_rst_wb_val", hs_ag4wb_val, 0);
        ls0 = ls_hs; wb0 = wb_hs;
        hs_ls4ag_rdy = 1'b1; hs_wb4ag_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hs_ls4ag_rdy = 1'b0; hs_wb4ag_rdy = 1'b0;
        chk("mid_rst_no_ls", ls_hs - ls0, 0);
        chk("mid_rst_no_wb", wb_hs - wb0, 0);

        for (int n = 0; n < 300; n++) begin
            do_op($urandom, 32'($urandom_range(0, 64)) - 32'd32,
                  3'($urandom_range(0, 7)), 1'($urandom),
                  $urandom, 5'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
